dmem_portb_arbiter: RTL
=======================

DMEM_PORTB_ARBITER -- requirements
Module: dmem_portb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, dmem word-address width.
REQ-002 Parameter DATA_W, default 32, dmem data width.
REQ-003 Parameter FIFO_DEPTH, default 4, keyboard write-queue entries (power of 2, >=2).
REQ-004 clock  in  1  single clock for all state.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 kb_we  in  1  keyboard-side write request, one entry per cycle high.
REQ-007 kb_addr  in  ADDR_W  write address, sampled with kb_we.
REQ-008 kb_data  in  DATA_W  write data, sampled with kb_we.
REQ-009 kb_ready  out  1  high when the queue can accept an entry this cycle.
REQ-010 vga_active  in  1  VGA requires a read this cycle.
REQ-011 vga_addr  in  ADDR_W  VGA read address.
REQ-012 vga_data  out  DATA_W  read data returned to VGA.
REQ-013 ram_addr  out  ADDR_W  dmem port-B address.
REQ-014 ram_data  out  DATA_W  dmem port-B write data.
REQ-015 ram_we  out  1  dmem port-B write enable.
REQ-016 ram_q  in  DATA_W  dmem port-B read data, 1-cycle synchronous latency.
REQ-017 fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-018 overflow  out  1  sticky flag: a write request was dropped.

Function
REQ-019 The block SHALL replace clock-gating of the VGA path; VGA clock SHALL never be gated by keyboard writes.
REQ-020 The queue SHALL be FIFO-ordered; head = oldest accepted entry.
REQ-021 kb_ready SHALL equal (level < FIFO_DEPTH) OR (pop this cycle).
REQ-022 kb_we with kb_ready high SHALL push {kb_addr, kb_data} at the clock edge.
REQ-023 kb_we with kb_ready low SHALL drop the entry and set overflow at that edge.
REQ-024 Simultaneous push and pop SHALL leave level unchanged, including at full and at level 1.
REQ-025 FSM states: S_READ, S_WRITE; registered state.
REQ-026 S_READ -> S_WRITE when vga_active==0 and level!=0; S_WRITE -> S_READ when vga_active==1, or level==1 with a pop and no push.
REQ-027 ram_we SHALL equal (state==S_WRITE) AND (level!=0) AND NOT vga_active; VGA wins combinationally in the same cycle.
REQ-028 When ram_we==1: ram_addr=head addr, ram_data=head data, head popped at that edge.
REQ-029 When ram_we==0: ram_addr=vga_addr, ram_data=0.
REQ-030 Maximum write throughput SHALL be one entry per cycle while vga_active==0; first write issues the cycle after entering S_WRITE.
REQ-031 vga_data SHALL reflect ram_q for the read issued one cycle earlier; no address forwarding from pending queue entries.
REQ-032 level and pointers SHALL wrap modulo FIFO_DEPTH without loss.
REQ-033 Continuous vga_active==1 SHALL stall writes indefinitely; entries SHALL be retained, not discarded.

Reset
REQ-034 On reset assertion, asynchronously: state=S_READ, level=0, pointers=0, overflow=0, ram_we=0, vga_data hold register=0.
REQ-035 Reset mid-write SHALL abort with no further ram_we; queued entries are lost.
REQ-036 overflow SHALL clear only on reset.

Configuration
REQ-037 Macro ARB_READ_HOLD_EN: defined -> vga_data is a register loaded from ram_q only on cycles following a read cycle, holding its value across write cycles; undefined -> vga_data = ram_q directly (combinational pass-through).

Structure
REQ-038 Shared package arb_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum (S_READ, S_WRITE) and the queue-entry struct {addr, data}.
REQ-039 Queue SHALL be a sub-module write_fifo (push, pop, full, empty, level, head outputs); FSM and muxing stay in dmem_portb_arbiter.

Verification
REQ-040 Reset, vga_active=0, kb_we once (addr 36, data 0x49) -> S_WRITE next cycle, then ram_we=1, ram_addr=36, ram_data=0x49 for one cycle, level 1->0.
REQ-041 vga_active=1 throughout, 4 pushes -> no ram_we, level=4, kb_ready=0; 5th push -> overflow=1, level stays 4; drop vga_active -> 4 writes in order on 4 consecutive cycles.
REQ-042 Level=4 during a write cycle plus simultaneous push -> push accepted, level stays 4, overflow=0.
REQ-043 Write in progress, vga_active rises -> ram_we=0 and ram_addr=vga_addr in that same cycle; queue resumes after vga_active falls.
REQ-044 With ARB_READ_HOLD_EN: read addr 10 (ram_q 0xAA) then write cycle (ram_q 0x55) -> vga_data stays 0xAA; without macro -> vga_data follows ram_q.
REQ-045 Reset asserted mid-burst with level=3 -> ram_we=0 immediately, level=0, overflow=0, state=S_READ.

Source files
------------

// File: rtl/dmem_portb_arbiter_pkg.sv
// Shared types for the dmem port-B arbiter: default widths,
// FSM state encoding and the keyboard write-queue entry.
package arb_pkg;

  localparam int ARB_ADDR_W     = 12;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_FIFO_DEPTH = 4;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/dmem_portb_arbiter_if.sv
// Keyboard / VGA / RAM port-B bundle for the arbiter.
// slave = arbiter side, master = surrounding system side.
interface dmem_portb_arbiter_if #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              kb_we;
  logic [ADDR_W-1:0] kb_addr;
  logic [DATA_W-1:0] kb_data;
  logic              kb_ready;
  logic              vga_active;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;

  modport slave (
    input  kb_we, kb_addr, kb_data,
    input  vga_active, vga_addr, ram_q,
    output kb_ready, vga_data,
    output ram_addr, ram_data, ram_we,
    output fifo_level, overflow
  );

  modport master (
    output kb_we, kb_addr, kb_data,
    output vga_active, vga_addr, ram_q,
    input  kb_ready, vga_data,
    input  ram_addr, ram_data, ram_we,
    input  fifo_level, overflow
  );

endinterface

// File: rtl/dmem_portb_arbiter_write_fifo.sv
// Keyboard write queue: power-of-2 circular buffer,
// head is the oldest entry, push+pop keeps the level.
module write_fifo #(
  parameter int  DEPTH  = 4,
  parameter type elem_t = arb_pkg::entry_t,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  elem_t            din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  output elem_t            head_o
);

  elem_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;

  // pointers wrap naturally at DEPTH
  always_comb begin
    wr_d  = push_i ? wr_q + 1'b1 : wr_q;
    rd_d  = pop_i  ? rd_q + 1'b1 : rd_q;
    lvl_d = lvl_q + LVL_W'(push_i) - LVL_W'(pop_i);
  end

  // pointer and occupancy registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // storage needs no reset; level gates validity
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign level_o = lvl_q;
  assign full_o  = (lvl_q == LVL_W'(DEPTH));
  assign empty_o = (lvl_q == '0);

endmodule

// File: rtl/dmem_portb_arbiter.sv
// Port-B arbiter: VGA reads always win, keyboard writes drain
// from a queue in idle cycles. ARB_READ_HOLD_EN registers vga_data.
module dmem_portb_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int FIFO_DEPTH = ARB_FIFO_DEPTH
) (
  input logic                 clock,
  input logic                 reset,
  dmem_portb_arbiter_if.slave bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_e           state_q, state_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, full, empty;
  logic             ram_we, kb_ready;
  logic [LVL_W-1:0] level;
  ent_t             din, head;

  assign din = '{addr: bus.kb_addr, data: bus.kb_data};

  write_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (ent_t)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level),
    .head_o  (head)
  );

  assign ram_we   = (state_q == S_WRITE) && !empty
                    && !bus.vga_active;
  assign pop      = ram_we;
  assign kb_ready = !full || pop;
  assign push     = bus.kb_we && kb_ready;

  // next state: drain when VGA idle, yield to VGA at once
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_READ: begin
        if (!bus.vga_active && !empty) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.vga_active)
          state_d = S_READ;
        else if (level == LVL_W'(1) && pop && !push)
          state_d = S_READ;
      end
      default: state_d = S_READ;
    endcase
  end

  // overflow is sticky until reset
  always_comb begin
    ovf_d = ovf_q || (bus.kb_we && !kb_ready);
  end

  // FSM state and overflow registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_READ;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = ram_we ? head.addr : bus.vga_addr;
  assign bus.ram_data   = ram_we ? head.data : '0;
  assign bus.kb_ready   = kb_ready;
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf_q;

`ifdef ARB_READ_HOLD_EN
  logic              rd_prev_q;
  logic [DATA_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = rd_prev_q ? bus.ram_q : hold_q;
  end

  // capture read data only after a read cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_prev_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      rd_prev_q <= !ram_we;
      hold_q    <= hold_d;
    end
  end

  assign bus.vga_data = hold_q;
`else
  assign bus.vga_data = bus.ram_q;
`endif

endmodule
